// File: rtl/or1k_icache_refill_ctrl.sv
// Instruction-cache line refill controller: issues a word burst on the
// instruction bus and streams each accepted beat straight into the cache.
// Optional macro OR1K_ICACHE_REFILL_CWF_EN enables critical-word-first order.
//
// Handshake: a beat transfers in any BURST cycle where ibus_ack_i is high and
// ibus_err_i is low; ibus_req_o/ibus_adr_o stay stable until that happens, and
// an error in BURST ends the refill regardless of ack.
module or1k_icache_refill_ctrl #(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            refill_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
  output logic                            ibus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
  output logic                            ibus_burst_o,
  input  logic                            ibus_ack_i,
  input  logic                            ibus_err_i,
  input  logic [31:0]                     ibus_dat_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
  output logic [31:0]                     wrdat_o,
  output logic                            we_o,
  output logic                            imem_err_o,
  output logic                            busy_o
);

  localparam int OW = OPTION_OPERAND_WIDTH;
  localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;
  localparam int IW = BW - 2;
  localparam logic [IW-1:0] LAST_BEAT = '1;
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [OW-1:BW]  tag_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   cnt_q;
  logic [IW-1:0]   start_idx;
  logic            launch;
  logic            beat_ok;
  logic            unused_adr_bits;

`ifdef OR1K_ICACHE_REFILL_CWF_EN
  assign start_idx       = refill_adr_i[BW-1:2];
  assign unused_adr_bits = ^refill_adr_i[1:0];
`else
  assign start_idx       = '0;
  assign unused_adr_bits = ^refill_adr_i[BW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A beat arriving in the same cycle as rst is dropped so no write leaks out.
  always_comb begin
    state_d      = state_q;
    ibus_req_o   = 1'b0;
    ibus_burst_o = 1'b0;
    we_o         = 1'b0;
    imem_err_o   = 1'b0;
    busy_o       = 1'b0;
    launch       = 1'b0;
    beat_ok      = 1'b0;
    case (state_q)
      IDLE: begin
        if (refill_req_i) begin
          launch  = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        busy_o       = 1'b1;
        ibus_req_o   = 1'b1;
        ibus_burst_o = (cnt_q != LAST_BEAT);
        if (ibus_err_i) begin
          imem_err_o = ~rst;
          state_d    = DONE;
        end else if (ibus_ack_i) begin
          we_o    = ~rst;
          beat_ok = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Only the word index advances; it wraps inside the line so the tag is fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else if (launch) begin
      tag_q <= refill_adr_i[OW-1:BW];
      idx_q <= start_idx;
      cnt_q <= '0;
    end else if (beat_ok) begin
      idx_q <= idx_q + IDX_ONE;
      cnt_q <= cnt_q + IDX_ONE;
    end
  end

  assign ibus_adr_o = {tag_q, idx_q, 2'b00};
  assign wradr_o    = ibus_adr_o;
  assign wrdat_o    = ibus_dat_i;

endmodule

// File: doc/or1k_icache_refill_ctrl.md
OR1K_ICACHE_REFILL_CTRL -- requirements
Module: or1k_icache_refill_ctrl

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32, giving the address and data width.
REQ-002 SHALL have parameter OPTION_ICACHE_BLOCK_WIDTH, default 5, giving the log2 of line bytes; legal values are 4 (4 words) and 5 (8 words).
REQ-003 SHALL have a single clock and a synchronous, active-high reset.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- refill_req_i  in  1  cache miss refill request
- refill_adr_i  in  OW  miss (critical) word address
- ibus_req_o  out  1  bus read request
- ibus_adr_o  out  OW  bus word address, bits [1:0] = 0
- ibus_burst_o  out  1  high = more beats follow; low = last beat
- ibus_ack_i  in  1  beat accepted, data valid
- ibus_err_i  in  1  bus error
- ibus_dat_i  in  32  read data
- wradr_o  out  OW  cache write address
- wrdat_o  out  32  cache write data
- we_o  out  1  cache write strobe
- imem_err_o  out  1  refill aborted by bus error
- busy_o  out  1  refill in progress

Function
REQ-005 SHALL implement the states IDLE, BURST and DONE.
REQ-006 IDLE & refill_req_i: SHALL latch refill_adr_i into the address register, clear the beat counter, and enter BURST; ibus_req_o goes high the next cycle.
REQ-007 In BURST: ibus_req_o=1; ibus_adr_o=address register.
REQ-008 On each ibus_ack_i in BURST (no error): we_o=1, wradr_o=ibus_adr_o, wrdat_o=ibus_dat_i, all in the same cycle (zero latency).
REQ-009 After each ack, the word index [BW-1:2] SHALL increment modulo the line size; the tag bits [OW-1:BW] SHALL never change.
REQ-010 The beat counter SHALL count acks; ibus_burst_o=0 while counter = words-1, otherwise 1.
REQ-011 The ack on the last beat SHALL move the FSM to DONE.
REQ-012 DONE SHALL last exactly one cycle, with no requests and refill_req_i ignored, then return to IDLE.
REQ-013 A cycle with no ack (wait state) SHALL hold the address, the counter and all outputs.
REQ-014 ibus_err_i in BURST SHALL pulse imem_err_o for 1 cycle with we_o=0, and move the FSM to DONE.
REQ-015 If ack and err arrive in the same cycle, err SHALL win and no write occurs.
REQ-016 refill_req_i while in BURST or DONE SHALL be ignored; there is no queuing.
REQ-017 busy_o SHALL be 1 in BURST and DONE.
REQ-018 ibus_ack_i and ibus_err_i outside BURST SHALL be ignored.
REQ-019 we_o SHALL never be asserted outside BURST.

Reset
REQ-020 rst SHALL force the FSM to IDLE on the next edge.
REQ-021 After reset: ibus_req_o, ibus_burst_o, we_o, imem_err_o and busy_o are 0; ibus_adr_o, wradr_o and the counter are 0.
REQ-022 rst mid-burst SHALL drop ibus_req_o the next cycle, with no further writes.
REQ-023 rst SHALL take precedence over every other event.

Configuration
REQ-024 Macro OR1K_ICACHE_REFILL_CWF_EN SHALL select the burst start word.
REQ-025 With OR1K_ICACHE_REFILL_CWF_EN defined: the burst SHALL start at refill_adr_i[BW-1:2] (critical word first) and wrap.
REQ-026 Without OR1K_ICACHE_REFILL_CWF_EN: the start word index SHALL be forced to 0 (linear fill); the beat count is unchanged.

Verification
REQ-027 CWF on, BW=5: req with adr 0x0000_1014, immediate acks -> 8 writes at 0x14,0x18,0x1C,0x00,0x04,0x08,0x0C,0x10 (offsets in 0x0000_1000 line); burst_o=0 only on 0x10; busy_o low after DONE.
REQ-028 CWF off, BW=4: req with adr 0x0000_2008 -> 4 writes at 0x2000,0x2004,0x2008,0x200C; burst_o low on 0x200C.
REQ-029 Wait states: ack only every 3rd cycle -> addresses held between acks, exactly 8 we_o pulses, wrdat_o equal to ibus_dat_i on each.
REQ-030 Error: err on beat 3 -> 2 writes, imem_err_o 1-cycle pulse, no we_o on beat 3, IDLE 2 cycles later.
REQ-031 Simultaneous ack+err on the first beat -> 0 writes, imem_err_o=1.
REQ-032 rst asserted mid-burst after beat 4 -> ibus_req_o=0 next cycle, all outputs at reset values; a new req starts cleanly.
REQ-033 refill_req_i held high through the last beat and DONE -> no second burst starts until the cycle after DONE.
